// File: rtl/car_sensor_cond.sv
// Synchronizes and debounces the country-road loop sensor, queues vehicles and drains them on country green.
// Arrival reaches queue DB_CYCLES+1 edges after sensor_raw is sampled; no backpressure, overflow is sticky at saturation.
module car_sensor_cond #(
    parameter int DB_CYCLES    = 4,
    parameter int CNT_W        = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             slowclk,
    input  logic             clr,
    input  logic             sensor_raw,
    input  logic [1:0]       cntry,
    output logic             X,
    output logic [CNT_W-1:0] queue,
    output logic             overflow
);
    localparam int               DRN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [3:0]       DB_LAST  = 4'(DB_CYCLES - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] Q_MAX    = '1;
    localparam logic [1:0]       GREEN    = 2'd2;

    typedef enum logic [1:0] {ABSENT, RISE_CHK, PRESENT, FALL_CHK} db_state_t;

    db_state_t        state;
    logic             s1;
    logic             s2;
    logic [3:0]       db_cnt;
    logic [DRN_W-1:0] drn_cnt;
    logic             arrival;
    logic             draining;
    logic             departure;

    // Events are combinational so the queue moves on the very edge the FSM/drain counter fires.
    assign arrival   = (state == RISE_CHK) && s2 && (db_cnt == DB_LAST);
    assign draining  = (cntry == GREEN) && (queue != '0);
    assign departure = draining && (drn_cnt == DRN_LAST);
    assign X         = (queue != '0);

    always_ff @(posedge slowclk) begin
        if (clr) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            state    <= ABSENT;
            db_cnt   <= '0;
            drn_cnt  <= '0;
            queue    <= '0;
            overflow <= 1'b0;
        end else begin
            s1 <= sensor_raw;
            s2 <= s1;

            case (state)
                ABSENT: begin
                    if (s2) begin
                        state  <= RISE_CHK;
                        db_cnt <= 4'd1;
                    end
                end
                RISE_CHK: begin
                    if (!s2) begin
                        state  <= ABSENT;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state  <= PRESENT;
                        db_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + 4'd1;
                    end
                end
                PRESENT: begin
                    if (!s2) begin
                        state  <= FALL_CHK;
                        db_cnt <= 4'd1;
                    end
                end
                FALL_CHK: begin
                    if (s2) begin
                        state  <= PRESENT;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state  <= ABSENT;
                        db_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + 4'd1;
                    end
                end
                default: begin
                    state  <= ABSENT;
                    db_cnt <= '0;
                end
            endcase

            if (draining) begin
                drn_cnt <= departure ? '0 : drn_cnt + DRN_W'(1);
            end else begin
                drn_cnt <= '0;
            end

            // Coincident arrival and departure cancel, leaving queue and overflow untouched.
            if (arrival && !departure) begin
                if (queue == Q_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    queue <= queue + CNT_W'(1);
                end
            end else if (departure && !arrival) begin
                queue <= queue - CNT_W'(1);
            end
        end
    end
endmodule
